// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand select, writeback forwarding, ALU control decode,
// one-entry valid/ready holding register with stall snooping. ALU_ISSUE_STATS_EN adds issue/stall counters.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_control,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       issue_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000,
                         ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BR = 7'b1100011;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic       {B_RS2, B_IMM}        b_sel_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
  } dec_t;

  // Shared R/I funct3 map; sub_ok distinguishes R-type add/sub from I-type addi.
  function automatic logic [3:0] fn_map(input logic [2:0] f3, input logic f7b5, input logic sub_ok);
    case (f3)
      3'b000:  fn_map = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  fn_map = ALU_SLL;
      3'b010:  fn_map = ALU_SLT;
      3'b011:  fn_map = ALU_SLTU;
      3'b100:  fn_map = ALU_XOR;
      3'b101:  fn_map = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  fn_map = ALU_OR;
      default: fn_map = ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] src_val(input logic [REG_AW-1:0] addr, input logic [XLEN-1:0] rf,
                                              input logic fv, input logic [REG_AW-1:0] frd,
                                              input logic [XLEN-1:0] fd);
    if (addr == '0)           src_val = '0;
    else if (fv && frd == addr) src_val = fd;
    else                      src_val = rf;
  endfunction

  dec_t dec;

  always_comb begin
    dec = '{ctrl: ALU_ADD, illegal: 1'b0, a_sel: A_RS1, b_sel: B_RS2};
    case (in_opcode)
      OP_R:  dec.ctrl = fn_map(in_funct3, in_funct7b5, 1'b1);
      OP_I: begin
        dec.b_sel = B_IMM;
        dec.ctrl  = fn_map(in_funct3, in_funct7b5, 1'b0);
        if (in_funct3 == 3'b001 && in_funct7b5) dec.illegal = 1'b1;
      end
      OP_LD, OP_ST: dec.b_sel = B_IMM;
      OP_LUI: begin
        dec.a_sel = A_ZERO;
        dec.b_sel = B_IMM;
      end
      OP_AUIPC: begin
        dec.a_sel = A_PC;
        dec.b_sel = B_IMM;
      end
      OP_BR: begin
        case (in_funct3[2:1])
          2'b00:   dec.ctrl = ALU_SUB;
          2'b10:   dec.ctrl = ALU_SLT;
          2'b11:   dec.ctrl = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.ctrl = ALU_ADD;
  end

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic              illegal_q, illegal_d;
  logic              a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic              capture, stall;

  assign in_ready = ~out_valid_q | out_ready;
  assign capture  = in_valid & in_ready & ~flush;
  assign stall    = out_valid_q & ~out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    ctrl_d      = ctrl_q;
    rd_d        = rd_q;
    illegal_d   = illegal_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    a_reg_d     = a_reg_q;
    b_reg_d     = b_reg_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec.ctrl;
      rd_d        = in_rd_addr;
      illegal_d   = dec.illegal;
      rs1_d       = in_rs1_addr;
      rs2_d       = in_rs2_addr;
      a_reg_d     = ~dec.illegal && dec.a_sel == A_RS1;
      b_reg_d     = ~dec.illegal && dec.b_sel == B_RS2;
      alu_a_d     = '0;
      alu_b_d     = '0;
      if (!dec.illegal) begin
        case (dec.a_sel)
          A_RS1:   alu_a_d = src_val(in_rs1_addr, in_rs1_data, fwd_valid, fwd_rd, fwd_data);
          A_PC:    alu_a_d = in_pc;
          default: alu_a_d = '0;
        endcase
        alu_b_d = (dec.b_sel == B_IMM) ? in_imm
                : src_val(in_rs2_addr, in_rs2_data, fwd_valid, fwd_rd, fwd_data);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else if (stall && fwd_valid && fwd_rd != '0) begin
      // Held operands track writebacks that land while we wait downstream.
      if (a_reg_q && fwd_rd == rs1_q) alu_a_d = fwd_data;
      if (b_reg_q && fwd_rd == rs2_q) alu_b_d = fwd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ctrl_q      <= ALU_ADD;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      a_reg_q     <= 1'b0;
      b_reg_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      a_reg_q     <= a_reg_d;
      b_reg_q     <= b_reg_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = ctrl_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + {31'd0, out_valid_q & out_ready};
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, forwarding, stall snoop, flush, reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [4:0] r1, input logic [31:0] d1,
                     input logic [4:0] r2, input logic [31:0] d2,
                     input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_rd_addr = rd; in_imm = imm; in_pc = pc;
  endtask

  // Fixed operands: rs1=x1 (0x11), rs2=x2 (0x22), imm=0x33, pc=0x44.
  task automatic dec_case(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [3:0] e_ctrl, input logic e_ill,
                          input logic [31:0] e_a, input logic [31:0] e_b);
    put(op, f3, f7, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33, 32'h44);
    step();
    chk({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".ctl"}, {28'd0, alu_control}, {28'd0, e_ctrl});
    chk({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, e_ill});
    chk({tag, ".a"}, alu_a, e_a);
    chk({tag, ".b"}, alu_b, e_b);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    put(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    #1;
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    chk("rst.a", alu_a, 32'd0);
    chk("rst.b", alu_b, 32'd0);
    chk("rst.ctl", {28'd0, alu_control}, 32'd0);
    chk("rst.rd", {27'd0, out_rd}, 32'd0);
    chk("rst.ill", {31'd0, out_illegal}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle.vld", {31'd0, out_valid}, 32'd0);

    // R sub x5(0x10) - x6(0x3)
    put(7'b0110011, 3'b000, 1'b1, 5'd5, 32'h10, 5'd6, 32'h3, 5'd12, 32'h0, 32'h0);
    step();
    chk("sub.vld", {31'd0, out_valid}, 32'd1);
    chk("sub.ctl", {28'd0, alu_control}, 32'd1);
    chk("sub.a", alu_a, 32'h10);
    chk("sub.b", alu_b, 32'h3);
    chk("sub.rd", {27'd0, out_rd}, 32'd12);

    // Forwarding at capture; x0 always reads zero
    put(7'b0110011, 3'b000, 1'b0, 5'd7, 32'h1, 5'd0, 32'h99, 5'd1, 32'h0, 32'h0);
    fwd_valid = 1'b1; fwd_rd = 5'd7; fwd_data = 32'hDEADBEEF;
    step();
    chk("fwd.a", alu_a, 32'hDEADBEEF);
    chk("fwd.b0", alu_b, 32'd0);
    put(7'b0110011, 3'b000, 1'b0, 5'd0, 32'h77, 5'd2, 32'h5, 5'd1, 32'h0, 32'h0);
    fwd_rd = 5'd0; fwd_data = 32'h1234;
    step();
    chk("fwd0.a", alu_a, 32'd0);
    chk("fwd0.b", alu_b, 32'h5);
    fwd_valid = 1'b0;

    // Decode table
    dec_case("add",   7'b0110011, 3'b000, 1'b0, 4'b0000, 1'b0, 32'h11, 32'h22);
    dec_case("sll",   7'b0110011, 3'b001, 1'b0, 4'b0110, 1'b0, 32'h11, 32'h22);
    dec_case("slt",   7'b0110011, 3'b010, 1'b0, 4'b0101, 1'b0, 32'h11, 32'h22);
    dec_case("sltu",  7'b0110011, 3'b011, 1'b0, 4'b1001, 1'b0, 32'h11, 32'h22);
    dec_case("xor",   7'b0110011, 3'b100, 1'b0, 4'b0100, 1'b0, 32'h11, 32'h22);
    dec_case("srl",   7'b0110011, 3'b101, 1'b0, 4'b0111, 1'b0, 32'h11, 32'h22);
    dec_case("sra",   7'b0110011, 3'b101, 1'b1, 4'b1000, 1'b0, 32'h11, 32'h22);
    dec_case("or",    7'b0110011, 3'b110, 1'b0, 4'b0011, 1'b0, 32'h11, 32'h22);
    dec_case("and",   7'b0110011, 3'b111, 1'b0, 4'b0010, 1'b0, 32'h11, 32'h22);
    dec_case("addi",  7'b0010011, 3'b000, 1'b1, 4'b0000, 1'b0, 32'h11, 32'h33);
    dec_case("slli7", 7'b0010011, 3'b001, 1'b1, 4'b0000, 1'b1, 32'h0,  32'h0);
    dec_case("srai",  7'b0010011, 3'b101, 1'b1, 4'b1000, 1'b0, 32'h11, 32'h33);
    dec_case("lw",    7'b0000011, 3'b010, 1'b0, 4'b0000, 1'b0, 32'h11, 32'h33);
    dec_case("sw",    7'b0100011, 3'b010, 1'b0, 4'b0000, 1'b0, 32'h11, 32'h33);
    dec_case("lui",   7'b0110111, 3'b000, 1'b0, 4'b0000, 1'b0, 32'h0,  32'h33);
    dec_case("bne",   7'b1100011, 3'b001, 1'b0, 4'b0001, 1'b0, 32'h11, 32'h22);
    dec_case("bge",   7'b1100011, 3'b101, 1'b0, 4'b0101, 1'b0, 32'h11, 32'h22);
    dec_case("bgeu",  7'b1100011, 3'b111, 1'b0, 4'b1001, 1'b0, 32'h11, 32'h22);
    dec_case("br01x", 7'b1100011, 3'b010, 1'b0, 4'b0000, 1'b1, 32'h0,  32'h0);

    // AUIPC and illegal opcode
    put(7'b0010111, 3'b000, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h2000, 32'h1000);
    step();
    chk("auipc.ctl", {28'd0, alu_control}, 32'd0);
    chk("auipc.a", alu_a, 32'h1000);
    chk("auipc.b", alu_b, 32'h2000);
    put(7'b1111111, 3'b000, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h2000, 32'h1000);
    step();
    chk("ill.vld", {31'd0, out_valid}, 32'd1);
    chk("ill.flag", {31'd0, out_illegal}, 32'd1);
    chk("ill.ctl", {28'd0, alu_control}, 32'd0);
    chk("ill.a", alu_a, 32'd0);
    chk("ill.b", alu_b, 32'd0);

    // Stall with snooping on both register-sourced operands
    put(7'b0110011, 3'b000, 1'b0, 5'd8, 32'h2, 5'd9, 32'h11, 5'd4, 32'h0, 32'h0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("stl.rdy0", {31'd0, in_ready}, 32'd0);
    step();
    chk("stl.vld", {31'd0, out_valid}, 32'd1);
    chk("stl.b0", alu_b, 32'h11);
    fwd_valid = 1'b1; fwd_rd = 5'd9; fwd_data = 32'h55;
    step();
    chk("stl.b", alu_b, 32'h55);
    chk("stl.a", alu_a, 32'h2);
    chk("stl.rdy1", {31'd0, in_ready}, 32'd0);
    fwd_rd = 5'd8; fwd_data = 32'hAA;
    step();
    fwd_valid = 1'b0;
    chk("stl.a2", alu_a, 32'hAA);
    chk("stl.b2", alu_b, 32'h55);
    out_ready = 1'b1;
    #1;
    chk("rel.rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("rel.vld", {31'd0, out_valid}, 32'd0);
    step();
    chk("rel.once", {31'd0, out_valid}, 32'd0);

    // Immediate operand must not be snooped via the unused rs2 field
    put(7'b0010011, 3'b000, 1'b0, 5'd3, 32'h5, 5'd4, 32'h66, 5'd2, 32'h9, 32'h0);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'h77;
    step();
    chk("imm.b", alu_b, 32'h9);
    fwd_rd = 5'd3; fwd_data = 32'h12;
    step();
    fwd_valid = 1'b0;
    chk("imm.a", alu_a, 32'h12);

    // Asynchronous reset while stalled
    #2 rst_n = 1'b0;
    #1;
    chk("arst.vld", {31'd0, out_valid}, 32'd0);
    chk("arst.a", alu_a, 32'd0);
    chk("arst.b", alu_b, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();

    // Flush while holding, then flush beating a capture
    put(7'b0110011, 3'b100, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 32'h0);
    step();
    out_ready = 1'b0; flush = 1'b1;
    put(7'b0110011, 3'b110, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 32'h0);
    step();
    chk("fl.vld", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl.drop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    chk("fl.cap", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Back-to-back stream, one op per cycle
    put(7'b0110011, 3'b000, 1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 32'h0);
    step();
    chk("b2b0.ctl", {28'd0, alu_control}, 32'd1);
    chk("b2b0.rdy", {31'd0, in_ready}, 32'd1);
    put(7'b0110011, 3'b100, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 32'h0);
    step();
    chk("b2b1.vld", {31'd0, out_valid}, 32'd1);
    chk("b2b1.ctl", {28'd0, alu_control}, 32'd4);
    put(7'b0110011, 3'b111, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 32'h0);
    step();
    chk("b2b2.vld", {31'd0, out_valid}, 32'd1);
    chk("b2b2.ctl", {28'd0, alu_control}, 32'd2);
    in_valid = 1'b0;
    step();
    chk("b2b.end", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
